// File: rtl/fsm_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fsm_input_arbiter
// Purpose : Round-robin burst scheduler sharing one 2-bit Mealy FSM among
//           NREQ requesters. Optional ARB_TIMEOUT_EN bounds bursts to MAX_BURST.
// Rev     : 1.0  initial release
// ============================================================================
module fsm_input_arbiter #(
    parameter int         NREQ      = 4,
    parameter int         IDW       = 2,
    parameter logic [1:0] IDLE_SYM  = 2'b00,
    parameter int         MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_sym,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [1:0]        fsm_input,
    input  logic [1:0]        fsm_output,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [1:0]        rsp_data,
    output logic              busy,
    output logic              burst_abort
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [IDW-1:0]  r_owner;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  w_pick;
    logic [IDW-1:0]  w_owner_inc;
    logic            w_any_valid;
    logic            w_owner_valid;
    logic            w_owner_last;
    logic [1:0]      w_owner_sym;
    logic            w_accept;
    logic            w_release;
    logic [NREQ-1:0] w_owner_onehot;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_cnt_limit = 8'(MAX_BURST - 1);
    logic [7:0] r_cnt;
    logic       r_abort;
    logic       w_abort;
`endif

    generate
        if (IDW != $clog2(NREQ) || NREQ < 2 || NREQ > 8 ||
            MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_params
            $error("fsm_input_arbiter: illegal parameter combination");
        end
    endgenerate

    // base + off, wrapped into 0..NREQ-1 (off never exceeds NREQ-1)
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // Scan downwards so the index closest to rr_ptr wins
    always_comb begin
        w_pick      = r_rr_ptr;
        w_any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(r_rr_ptr, k)]) begin
                w_pick      = wrap_add(r_rr_ptr, k);
                w_any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_owner_valid = 1'b0;
        w_owner_last  = 1'b0;
        w_owner_sym   = IDLE_SYM;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IDW'(i)) begin
                w_owner_valid = req_valid[i];
                w_owner_last  = req_last[i];
                w_owner_sym   = req_sym[2*i +: 2];
            end
        end
    end

    assign w_owner_inc    = wrap_add(r_owner, 1);
    assign w_owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        fsm_input    = IDLE_SYM;
        w_accept     = 1'b0;
        w_release    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_abort      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any_valid) begin
                    w_next_state = S_BURST;
                end
            end
            S_BURST: begin
                w_accept  = w_owner_valid;
                req_ready = w_owner_onehot & req_valid;
                if (w_accept) begin
                    fsm_input = w_owner_sym;
                    if (w_owner_last) begin
                        w_release = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    end else if (r_cnt == c_cnt_limit) begin
                        w_release = 1'b1;
                        w_abort   = 1'b1;
`endif
                    end
                end
                if (w_release) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= w_accept;
            if (w_accept) begin
                rsp_id   <= r_owner;
                rsp_data <= fsm_output;
            end
            if (r_state == S_IDLE && w_any_valid) begin
                r_owner <= w_pick;
            end
            if (w_release) begin
                r_rr_ptr <= w_owner_inc;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_abort;
            if (r_state == S_IDLE && w_any_valid) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign burst_abort = r_abort;
`else
    assign burst_abort = 1'b0;
`endif

    assign busy = (r_state == S_BURST);

endmodule
`default_nettype wire

// File: tb/tb_fsm_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fsm_input_arbiter
// Purpose : Cycle model plus response scoreboard for fsm_input_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fsm_input_arbiter;

    localparam int         NREQ  = 4;
    localparam int         IDW   = 2;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam int         MB    = 4;
    localparam int         DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [2*NREQ-1:0] req_sym = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic [1:0]        fsm_input;
    logic [1:0]        fsm_output;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [1:0]        rsp_data;
    logic              busy;
    logic              burst_abort;

    // Stand-in for the downstream Mealy FSM
    assign fsm_output = fsm_input ^ 2'b11;

    always #5 clk = ~clk;

    fsm_input_arbiter #(
        .NREQ      (NREQ),
        .IDW       (IDW),
        .IDLE_SYM  (IDLE),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_sym     (req_sym),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fsm_input   (fsm_input),
        .fsm_output  (fsm_output),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .burst_abort (burst_abort)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-requester symbol buffers: {last, sym}, with idle cycles before each entry
    logic [2:0]      sbuf    [NREQ][DEPTH];
    int              pre_gap [NREQ][DEPTH];
    int              head    [NREQ];
    int              tail    [NREQ];
    logic [NREQ-1:0] ready_seen = '0;

    bit         m_busy = 1'b0;
    int         m_owner = 0;
    int         m_ptr = 0;
    int         m_cnt = 0;
    bit         m_pend = 1'b0;
    bit         m_abort = 1'b0;
    logic [1:0] m_rid = '0;
    logic [1:0] m_rdata = '0;
    logic [3:0] exp_q[$];
    int         order_log[$];
    int         abort_seen = 0;

    task automatic clear_bufs();
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        order_log.delete();
    endtask

    task automatic push_sym(input int r, input logic [1:0] s, input logic last, input int gap);
        sbuf[r][tail[r]]    = {last, s};
        pre_gap[r][tail[r]] = gap;
        tail[r]++;
    endtask

    task automatic drive_step();
        for (int i = 0; i < NREQ; i++) begin
            if (ready_seen[i] && head[i] < tail[i]) head[i]++;
            if (head[i] < tail[i] && pre_gap[i][head[i]] == 0) begin
                req_valid[i]       = 1'b1;
                req_sym[2*i +: 2]  = sbuf[i][head[i]][1:0];
                req_last[i]        = sbuf[i][head[i]][2];
            end else begin
                if (head[i] < tail[i]) pre_gap[i][head[i]]--;
                req_valid[i]       = 1'b0;
                req_sym[2*i +: 2]  = 2'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_step();
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < NREQ; i++) if (head[i] < tail[i]) e = 1'b0;
        return e;
    endfunction

    task automatic run_drain(input string tag, input int max_cycles);
        int c = 0;
        drive_step();
        while (!(all_empty() && !m_busy && !m_pend) && c < max_cycles) begin
            step();
            c++;
        end
        repeat (2) step();
        check({tag, "_drain"}, 32'(c < max_cycles), 32'd1);
    endtask

    task automatic check_order(input string tag, input int exp_ids[]);
        check({tag, "_count"}, 32'(order_log.size()), 32'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size(); i++) begin
            check({tag, "_id"}, (i < order_log.size()) ? 32'(order_log[i]) : 32'hFFFF, 32'(exp_ids[i]));
        end
    endtask

    // Reference model and scoreboard, evaluated on the falling edge
    always @(negedge clk) begin
        logic [NREQ-1:0] e_ready;
        logic            acc;
        logic [1:0]      sym;
        logic            rel;
        logic            ab;
        logic [3:0]      e;
        if (!reset) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
            m_pend = 1'b0; m_abort = 1'b0; m_rid = '0; m_rdata = '0;
            exp_q.delete();
        end
        e_ready = '0;
        acc     = 1'b0;
        sym     = IDLE;
        if (m_busy && req_valid[m_owner]) begin
            acc              = 1'b1;
            e_ready[m_owner] = 1'b1;
            sym              = req_sym[2*m_owner +: 2];
        end
        check("req_ready",   32'(req_ready),   32'(e_ready));
        check("fsm_input",   32'(fsm_input),   32'(sym));
        check("busy",        32'(busy),        32'(m_busy));
        check("rsp_valid",   32'(rsp_valid),   32'(m_pend));
        check("burst_abort", 32'(burst_abort), 32'(m_abort));
        if (burst_abort) abort_seen++;
        if (rsp_valid) begin
            order_log.push_back(int'(rsp_id));
            check("rsp_q_depth", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_id",   32'(rsp_id),   32'(e[3:2]));
                check("rsp_data", 32'(rsp_data), 32'(e[1:0]));
            end
        end else begin
            check("rsp_id_hold",   32'(rsp_id),   32'(m_rid));
            check("rsp_data_hold", 32'(rsp_data), 32'(m_rdata));
        end
        ready_seen = req_ready;
        if (reset) begin
            m_pend = acc;
            ab     = 1'b0;
            if (acc) begin
                exp_q.push_back({2'(m_owner), sym ^ 2'b11});
                m_rid   = 2'(m_owner);
                m_rdata = sym ^ 2'b11;
            end
            if (m_busy) begin
                if (acc) begin
                    rel = req_last[m_owner];
`ifdef ARB_TIMEOUT_EN
                    if (!rel && m_cnt == MB - 1) begin
                        rel = 1'b1;
                        ab  = 1'b1;
                    end
`endif
                    m_cnt++;
                    if (rel) begin
                        m_busy = 1'b0;
                        m_ptr  = (m_owner + 1) % NREQ;
                    end
                end
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!m_busy && req_valid[(m_ptr + k) % NREQ]) begin
                        m_owner = (m_ptr + k) % NREQ;
                        m_busy  = 1'b1;
                        m_cnt   = 0;
                    end
                end
            end
            m_abort = ab;
        end
    end

    initial begin
        int c;
        int abort_base;
        clear_bufs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  32'(busy),      32'd0);
        check("reset_fin",   32'(fsm_input), 32'(IDLE));
        check("reset_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;

        // Single back-to-back burst from requester 0
        clear_bufs();
        push_sym(0, 2'b10, 1'b0, 0);
        push_sym(0, 2'b11, 1'b0, 0);
        push_sym(0, 2'b00, 1'b1, 0);
        run_drain("t1", 40);
        check_order("t1_order", '{0, 0, 0});

        // Simultaneous req0/req2 with rr_ptr at 1: req2 wins
        clear_bufs();
        push_sym(0, 2'b01, 1'b1, 0);
        push_sym(2, 2'b11, 1'b0, 0);
        push_sym(2, 2'b10, 1'b1, 0);
        run_drain("t2", 40);
        check_order("t2_order", '{2, 2, 0});

        // Requester 1 drops valid for two cycles mid-burst
        clear_bufs();
        push_sym(1, 2'b01, 1'b0, 0);
        push_sym(1, 2'b10, 1'b0, 0);
        push_sym(1, 2'b11, 1'b0, 2);
        push_sym(1, 2'b01, 1'b1, 0);
        run_drain("t3", 40);
        check_order("t3_order", '{1, 1, 1, 1});

        // Move rr_ptr back to 0
        clear_bufs();
        push_sym(3, 2'b10, 1'b1, 0);
        run_drain("t3b", 40);

        // All requesters continuously valid with one-symbol bursts
        clear_bufs();
        push_sym(0, 2'b01, 1'b1, 0);
        push_sym(0, 2'b10, 1'b1, 0);
        push_sym(1, 2'b11, 1'b1, 0);
        push_sym(2, 2'b10, 1'b1, 0);
        push_sym(3, 2'b01, 1'b1, 0);
        run_drain("t6", 60);
        check_order("t6_order", '{0, 1, 2, 3, 0});

`ifdef ARB_TIMEOUT_EN
        // Requester 3 overruns MAX_BURST while requester 0 waits
        clear_bufs();
        abort_base = abort_seen;
        for (int i = 0; i < 6; i++) push_sym(3, 2'(i + 1), 1'b0, 0);
        push_sym(3, 2'b10, 1'b1, 0);
        push_sym(0, 2'b11, 1'b1, 0);
        run_drain("t5", 80);
        check_order("t5_order", '{3, 3, 3, 3, 0, 3, 3, 3});
        check("t5_aborts", 32'(abort_seen - abort_base), 32'd1);
`endif

        // Reset during the second symbol of a burst
        clear_bufs();
        push_sym(1, 2'b01, 1'b0, 0);
        push_sym(1, 2'b10, 1'b0, 0);
        push_sym(1, 2'b11, 1'b1, 0);
        drive_step();
        c = 0;
        while (head[1] < 1 && c < 20) begin
            step();
            c++;
        end
        check("t4_reach_sym2", 32'(c < 20), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t4_busy",      32'(busy),        32'd0);
        check("t4_ready",     32'(req_ready),   32'd0);
        check("t4_fin",       32'(fsm_input),   32'(IDLE));
        check("t4_rsp_valid", 32'(rsp_valid),   32'd0);
        check("t4_rsp_id",    32'(rsp_id),      32'd0);
        check("t4_rsp_data",  32'(rsp_data),    32'd0);
        check("t4_abort",     32'(burst_abort), 32'd0);
        clear_bufs();
        ready_seen = '0;
        drive_step();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        push_sym(3, 2'b11, 1'b1, 0);
        push_sym(0, 2'b10, 1'b1, 0);
        run_drain("t4", 40);
        check_order("t4_order", '{0, 3});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
